// File: rtl/magic_seq_pkg.sv
// Shared types and encodings for the MAGIC crossbar gate sequencer.
// The program word layout is {opc, src_a, src_b, dst}, MSB first.
package magic_seq_pkg;

    // Sequencer control states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_INIT   = 3'd3,
        S_EVAL   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    // Crossbar driver command encodings.
    typedef enum logic [1:0] {
        CMD_INIT = 2'b00,
        CMD_NOT  = 2'b01,
        CMD_NOR  = 2'b10
    } cmd_e;

    // Gate opcode stored in the program word.
    localparam logic OPC_NOT = 1'b0;
    localparam logic OPC_NOR = 1'b1;

    // Total program word width for a given cell index width.
    function automatic int prog_w(input int addr_w);
        return 1 + 3 * addr_w;
    endfunction

    // Field offsets inside the program word.
    function automatic int dst_lsb(input int addr_w);
        return 0 * addr_w;
    endfunction

    function automatic int src_b_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int src_a_lsb(input int addr_w);
        return 2 * addr_w;
    endfunction

    function automatic int opc_bit(input int addr_w);
        return 3 * addr_w;
    endfunction

endpackage

// File: rtl/magic_op_decode.sv
// Combinational split of a program word into its fields, plus the
// write-after-read hazard check: a MAGIC gate must never overwrite one
// of its own operand cells, since INIT would destroy the operand first.
module magic_op_decode
    import magic_seq_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic [prog_w(ADDR_W)-1:0] prog_word_i,
    output logic                      opc_o,
    output logic [ADDR_W-1:0]         src_a_o,
    output logic [ADDR_W-1:0]         src_b_o,
    output logic [ADDR_W-1:0]         dst_o,
    output logic                      hazard_o
);

    localparam int OPC_POS   = opc_bit(ADDR_W);
    localparam int SRC_A_POS = src_a_lsb(ADDR_W);
    localparam int SRC_B_POS = src_b_lsb(ADDR_W);
    localparam int DST_POS   = dst_lsb(ADDR_W);

    logic              opc;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;

    // Field extraction and hazard detection; src_b only matters for NOR.
    always_comb begin
        opc      = prog_word_i[OPC_POS];
        src_a    = prog_word_i[SRC_A_POS +: ADDR_W];
        src_b    = prog_word_i[SRC_B_POS +: ADDR_W];
        dst      = prog_word_i[DST_POS +: ADDR_W];
        hazard_o = (dst == src_a) || ((opc == OPC_NOR) && (dst == src_b));
        opc_o    = opc;
        src_a_o  = src_a;
        src_b_o  = src_b;
        dst_o    = dst;
    end

endmodule

// File: rtl/magic_gate_sequencer.sv
// Steps through a NOR/NOT gate program held in a synchronous ROM and
// issues an INIT then an EVAL command per gate to a MAGIC crossbar row.
// All crossbar outputs are decoded from registered state, so ready never
// reaches valid combinationally and the payload is stable while stalled.
module magic_gate_sequencer
    import magic_seq_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int PC_W    = 7,
    parameter int NUM_OPS = 90
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      abort_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [PC_W:0]             op_count_o,
    output logic [PC_W-1:0]           prog_addr_o,
    input  logic [prog_w(ADDR_W)-1:0] prog_data_i,
    output logic                      xbar_cmd_valid_o,
    input  logic                      xbar_cmd_ready_i,
    output logic [1:0]                xbar_cmd_op_o,
    output logic [ADDR_W-1:0]         xbar_src_a_o,
    output logic [ADDR_W-1:0]         xbar_src_b_o,
    output logic [ADDR_W-1:0]         xbar_dst_o
);

    localparam logic [PC_W-1:0] LAST_PC   = PC_W'(NUM_OPS - 1);
    localparam logic [PC_W:0]   MAX_COUNT = (PC_W + 1)'(NUM_OPS);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W:0]     count_q, count_d;
    logic              err_q, err_d;
    logic              abort_pend_q, abort_pend_d;
    logic              op_opc_q, op_opc_d;
    logic [ADDR_W-1:0] op_src_a_q, op_src_a_d;
    logic [ADDR_W-1:0] op_src_b_q, op_src_b_d;
    logic [ADDR_W-1:0] op_dst_q, op_dst_d;

    logic              dec_opc;
    logic [ADDR_W-1:0] dec_src_a;
    logic [ADDR_W-1:0] dec_src_b;
    logic [ADDR_W-1:0] dec_dst;
    logic              dec_hazard;

    logic              cmd_valid;
    cmd_e              cmd_op;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;
    logic              done_pulse;
    logic              handshake;

    magic_op_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .prog_word_i (prog_data_i),
        .opc_o       (dec_opc),
        .src_a_o     (dec_src_a),
        .src_b_o     (dec_src_b),
        .dst_o       (dec_dst),
        .hazard_o    (dec_hazard)
    );

    // Next-state, datapath update and crossbar command generation.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;
        op_opc_d     = op_opc_q;
        op_src_a_d   = op_src_a_q;
        op_src_b_d   = op_src_b_q;
        op_dst_d     = op_dst_q;
        cmd_valid    = 1'b0;
        cmd_op       = CMD_INIT;
        cmd_src_a    = '0;
        cmd_src_b    = '0;
        cmd_dst      = '0;
        done_pulse   = 1'b0;
        handshake    = 1'b0;

        // An abort seen in any busy state is remembered until the next
        // point where the program would fetch another op.
        if ((state_q != S_IDLE) && abort_i) begin
            abort_pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                abort_pend_d = 1'b0;
                if (start_i) begin
                    pc_d    = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                op_opc_d   = dec_opc;
                op_src_a_d = dec_src_a;
                op_src_b_d = dec_src_b;
                op_dst_d   = dec_dst;
                if (dec_hazard) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    state_d = S_INIT;
                end
            end

            S_INIT: begin
                cmd_valid = 1'b1;
                cmd_op    = CMD_INIT;
                cmd_dst   = op_dst_q;
                handshake = xbar_cmd_ready_i;
                if (handshake) begin
                    state_d = S_EVAL;
                end
            end

            S_EVAL: begin
                cmd_valid = 1'b1;
                cmd_op    = (op_opc_q == OPC_NOT) ? CMD_NOT : CMD_NOR;
                cmd_src_a = op_src_a_q;
                cmd_src_b = (op_opc_q == OPC_NOT) ? '0 : op_src_b_q;
                cmd_dst   = op_dst_q;
                handshake = xbar_cmd_ready_i;
                if (handshake) begin
                    if (count_q != MAX_COUNT) begin
                        count_d = count_q + 1'b1;
                    end
                    if (pc_q == LAST_PC) begin
                        // The final op always completes, even with an abort pending.
                        state_d = S_DONE;
                    end else if (abort_pend_d) begin
                        abort_pend_d = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                done_pulse   = 1'b1;
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end

            S_ERR: begin
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset on control only.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its _d value from before this edge.
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Op register; it is only read in INIT/EVAL after a DECODE has loaded it.
    always_ff @(posedge clk) begin
        // NOTE: the op register is deliberately left out of reset; its
        // contents are never visible until DECODE has written it.
        op_opc_q   <= op_opc_d;
        op_src_a_q <= op_src_a_d;
        op_src_b_q <= op_src_b_d;
        op_dst_q   <= op_dst_d;
    end

    // Output mapping from registered state only.
    always_comb begin
        busy_o           = (state_q != S_IDLE);
        done_o           = done_pulse;
        err_o            = err_q;
        op_count_o       = count_q;
        prog_addr_o      = pc_q;
        xbar_cmd_valid_o = cmd_valid;
        xbar_cmd_op_o    = cmd_op;
        xbar_src_a_o     = cmd_src_a;
        xbar_src_b_o     = cmd_src_b;
        xbar_dst_o       = cmd_dst;
    end

endmodule

// File: tb/tb_magic_gate_sequencer.sv
// Self-checking bench for magic_gate_sequencer. Two instances share the
// clock, reset, abort and ready inputs: one with a 4-op program and one
// with the default 90-op program. Only one is started at a time.
module tb_magic_gate_sequencer;

    localparam int AW  = 7;
    localparam int PW  = 7;
    localparam int PRW = 1 + 3 * AW;

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] d;
    } cmd_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_u [2];
    logic           abort;
    logic           xr;
    logic           busy [2];
    logic           done [2];
    logic           err [2];
    logic [PW:0]    op_count [2];
    logic [PW-1:0]  prog_addr [2];
    logic [PRW-1:0] prog_data [2];
    logic           valid [2];
    logic [1:0]     cmd_op [2];
    logic [AW-1:0]  src_a [2];
    logic [AW-1:0]  src_b [2];
    logic [AW-1:0]  dst [2];

    logic [PRW-1:0] rom [128];

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   act      = 0;
    int   rmode    = 0;
    int   init_wait = 0;

    // Reference model state.
    cmd_t exp_q [$];
    int   exp_ops;
    bit   exp_err;
    int   c0;
    int   hs_idx;
    int   stalls;
    int   done_cnt;
    int   done_cyc;
    int   first_hs;
    bit   prev_stall;
    cmd_t prev_pay;

    magic_gate_sequencer #(.ADDR_W(AW), .PC_W(PW), .NUM_OPS(4)) u_small (
        .clk(clk), .rst(rst), .start_i(start_u[0]), .abort_i(abort),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
        .op_count_o(op_count[0]), .prog_addr_o(prog_addr[0]), .prog_data_i(prog_data[0]),
        .xbar_cmd_valid_o(valid[0]), .xbar_cmd_ready_i(xr), .xbar_cmd_op_o(cmd_op[0]),
        .xbar_src_a_o(src_a[0]), .xbar_src_b_o(src_b[0]), .xbar_dst_o(dst[0])
    );

    magic_gate_sequencer u_big (
        .clk(clk), .rst(rst), .start_i(start_u[1]), .abort_i(abort),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
        .op_count_o(op_count[1]), .prog_addr_o(prog_addr[1]), .prog_data_i(prog_data[1]),
        .xbar_cmd_valid_o(valid[1]), .xbar_cmd_ready_i(xr), .xbar_cmd_op_o(cmd_op[1]),
        .xbar_src_a_o(src_a[1]), .xbar_src_b_o(src_b[1]), .xbar_dst_o(dst[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous program ROM, one read port per instance.
    always @(posedge clk) begin
        prog_data[0] <= rom[prog_addr[0]];
        prog_data[1] <= rom[prog_addr[1]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic logic [PRW-1:0] mk(input logic opc, input logic [AW-1:0] a,
                                          input logic [AW-1:0] b, input logic [AW-1:0] d);
        return {opc, a, b, d};
    endfunction

    function automatic bit is_hazard(input logic [PRW-1:0] w);
        logic [AW-1:0] a, b, d;
        a = w[2*AW +: AW];
        b = w[AW +: AW];
        d = w[0 +: AW];
        return (d == a) || (w[3*AW] && (d == b));
    endfunction

    function automatic logic [PRW-1:0] rand_safe_word();
        logic [PRW-1:0] w;
        w = PRW'($urandom);
        while (is_hazard(w)) w = PRW'($urandom);
        return w;
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 128; i++) rom[i] = rand_safe_word();
    endtask

    // Expected command stream: INIT(dst) then the gate, per op, until a hazard.
    task automatic build_expect(input int n);
        cmd_t c;
        logic [PRW-1:0] w;
        exp_q.delete();
        exp_err = 1'b0;
        exp_ops = 0;
        for (int i = 0; i < n; i++) begin
            w = rom[i];
            if (is_hazard(w)) begin
                exp_err = 1'b1;
                break;
            end
            c.op = 2'b00; c.a = '0; c.b = '0; c.d = w[0 +: AW];
            exp_q.push_back(c);
            c.op = w[3*AW] ? 2'b10 : 2'b01;
            c.a  = w[2*AW +: AW];
            c.b  = w[3*AW] ? w[AW +: AW] : '0;
            c.d  = w[0 +: AW];
            exp_q.push_back(c);
            exp_ops++;
        end
    endtask

    task automatic reset_model();
        hs_idx = 0; stalls = 0; done_cnt = 0; done_cyc = -1;
        first_hs = -1; prev_stall = 1'b0;
    endtask

    // Ready driver, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rmode)
            1: xr = ($urandom_range(0, 9) < 6);
            2: begin
                if (valid[act] && cmd_op[act] == 2'b00 && init_wait < 3) begin
                    xr = 1'b0;
                    init_wait++;
                end else begin
                    xr = 1'b1;
                    if (!(valid[act] && cmd_op[act] == 2'b00)) init_wait = 0;
                end
            end
            default: xr = 1'b1;
        endcase
    end

    // Compare process: every handshake against the model, stall stability,
    // handshake timing, done pulse bookkeeping.
    always @(negedge clk) begin
        cmd_t got, e;
        int   exp_cyc;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            got = {cmd_op[act], src_a[act], src_b[act], dst[act]};
            check("idle_unit_valid", 32'(valid[1-act]), 0);
            if (prev_stall) begin
                check("stall_valid_held", 32'(valid[act]), 1);
                check("stall_payload", 32'(got), 32'(prev_pay));
            end
            if (valid[act] && xr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 32'(got), 0);
                    check("unexpected_cmd_count", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_op", 32'(got.op), 32'(e.op));
                    check("cmd_src_a", 32'(got.a), 32'(e.a));
                    check("cmd_src_b", 32'(got.b), 32'(e.b));
                    check("cmd_dst", 32'(got.d), 32'(e.d));
                    exp_cyc = c0 + 4 * (hs_idx / 2) + 3 + (hs_idx % 2) + stalls;
                    check("hs_cycle", cyc, exp_cyc);
                end
                if (first_hs < 0) first_hs = cyc;
                hs_idx++;
            end
            if (valid[act] && !xr) stalls++;
            prev_stall = valid[act] && !xr;
            prev_pay   = got;
            if (done[act]) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic launch(input int u);
        @(posedge clk); #1;
        act = u;
        reset_model();
        c0 = cyc;
        start_u[u] = 1'b1;
        @(posedge clk); #1;
        start_u[u] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[act] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy[act]), 0);
    endtask

    task automatic end_checks(input int exp_done, input int done_off, input int exp_hs,
                              input int exp_cnt, input int exp_e);
        check("done_count", done_cnt, exp_done);
        if (exp_done != 0) check("done_cycle", done_cyc - c0, done_off);
        check("handshakes", hs_idx, exp_hs);
        check("cmds_left", exp_q.size(), 0);
        check("op_count", 32'(op_count[act]), exp_cnt);
        check("err", 32'(err[act]), exp_e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_u[0] = 1'b0; start_u[1] = 1'b0; abort = 1'b0; xr = 1'b1;
        fill_rom();
        reset_model();
        c0 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_busy", 32'(busy[u]), 0);
            check("rst_done", 32'(done[u]), 0);
            check("rst_err", 32'(err[u]), 0);
            check("rst_valid", 32'(valid[u]), 0);
            check("rst_op_count", 32'(op_count[u]), 0);
            check("rst_prog_addr", 32'(prog_addr[u]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // 4 ops, ready high: done in cycle 17, idle in 18.
        build_expect(4);
        launch(0);
        wait_idle(200);
        check("t1_first_hs", first_hs - c0, 3);
        check("t1_idle_cycle", cyc - c0, 18);
        end_checks(1, 17, 8, 4, 0);

        // 3 stall cycles at each INIT: done in cycle 29.
        rmode = 2;
        build_expect(4);
        launch(0);
        wait_idle(200);
        end_checks(1, 29, 8, 4, 0);
        rmode = 0;

        // Hazard on op1: NOR writing its own operand B.
        rom[1] = mk(1'b1, 7'd9, 7'd5, 7'd5);
        build_expect(4);
        launch(0);
        wait_idle(200);
        check("hz_idle_cycle", cyc - c0, 8);
        end_checks(0, 0, 2, 1, 1);
        rom[1] = mk(1'b0, 7'd9, 7'd5, 7'd6);
        build_expect(4);
        launch(0);
        @(negedge clk);
        check("err_cleared_on_start", 32'(err[0]), 0);
        wait_idle(200);
        end_checks(1, 17, 8, 4, 0);

        // Abort during op1: op1 still completes, then idle without done.
        build_expect(4);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        launch(0);
        while (cyc < c0 + 6) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(200);
        check("abort_idle_cycle", cyc - c0, 9);
        end_checks(0, 0, 4, 2, 0);

        // start held while busy, then reset in cycle 10.
        build_expect(4);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        @(posedge clk); #1;
        act = 0; reset_model(); c0 = cyc; start_u[0] = 1'b1;
        while (cyc < c0 + 10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_u[0] = 1'b0;
        @(negedge clk);
        check("rr_busy", 32'(busy[0]), 0);
        check("rr_valid", 32'(valid[0]), 0);
        check("rr_done", 32'(done[0]), 0);
        check("rr_op_count", 32'(op_count[0]), 0);
        check("rr_prog_addr", 32'(prog_addr[0]), 0);
        check("rr_handshakes", hs_idx, 4);
        check("rr_cmds_left", exp_q.size(), 0);
        build_expect(4);
        launch(0);
        wait_idle(200);
        end_checks(1, 17, 8, 4, 0);

        // Random 4-op programs with random ready and occasional hazards.
        rmode = 1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) rom[i] = rand_safe_word();
            if ($urandom_range(0, 1) == 1)
                rom[$urandom_range(0, 3)] = mk(1'b1, 7'd3, 7'd40, 7'd40);
            build_expect(4);
            launch(0);
            wait_idle(400);
            end_checks(exp_err ? 0 : 1, 4 * 4 + 1 + stalls, 2 * exp_ops, exp_ops, 32'(exp_err));
        end
        rmode = 0;

        // Default 90-op program, ready high: done in cycle 361.
        fill_rom();
        build_expect(90);
        launch(1);
        wait_idle(1000);
        end_checks(1, 361, 180, 90, 0);

        // Default 90-op program, randomly throttled ready.
        fill_rom();
        rmode = 1;
        build_expect(90);
        launch(1);
        wait_idle(3000);
        end_checks(1, 4 * 90 + 1 + stalls, 180, 90, 0);
        rmode = 0;

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
